// File: rtl/prv664_mscoreboard.sv
// Multi-port register scoreboard: dispatch marks registers busy with an owner itag, commit/flush clear them.
// Optional PRV664_SCB_COMMIT_BYPASS_EN: a qualifying commit also clears busy_o combinationally in the same cycle.
module prv664_mscoreboard #(
  parameter  int NREG           = 32,
  parameter  int IDLEN          = 8,
  parameter  int NWR            = 2,
  parameter  int NCM            = 2,
  parameter  int ITAG_CHECK     = 1,
  parameter  int ZERO_HARDWIRED = 1,
  localparam int IW             = $clog2(NREG),
  localparam int CW             = $clog2(NREG + 1)
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  flush_i,
  input  logic [NWR-1:0]        upd_valid_i,
  input  logic [NWR*IW-1:0]     upd_rdindex_i,
  input  logic [NWR*IDLEN-1:0]  upd_itag_i,
  input  logic [NCM-1:0]        cm_valid_i,
  input  logic [NCM-1:0]        cm_wren_i,
  input  logic [NCM*IW-1:0]     cm_rdindex_i,
  input  logic [NCM*IDLEN-1:0]  cm_itag_i,
  output logic [NREG-1:0]       busy_o,
  output logic [NREG*IDLEN-1:0] itag_o,
  output logic [CW-1:0]         busy_cnt_o
);

  logic [NREG-1:0]  busy_q, busy_d;
  logic [IDLEN-1:0] itag_q [NREG];
  logic [IDLEN-1:0] itag_d [NREG];
  logic [NREG-1:0]  upd_hit, cm_hit;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Indices >= NREG can never equal IW'(i) for i < NREG, so out-of-range
  // updates and commits fall through without an explicit bounds check.
  always_comb begin
    busy_d  = busy_q;
    upd_hit = '0;
    cm_hit  = '0;
    for (int i = 0; i < NREG; i++) begin
      itag_d[i] = itag_q[i];
    end

    for (int i = 0; i < NREG; i++) begin
      // Ascending port order leaves the youngest hitting port's itag in place.
      for (int k = 0; k < NWR; k++) begin
        if (upd_valid_i[k] && (upd_rdindex_i[k*IW +: IW] == IW'(i))) begin
          upd_hit[i] = 1'b1;
          itag_d[i]  = upd_itag_i[k*IDLEN +: IDLEN];
        end
      end
      for (int c = 0; c < NCM; c++) begin
        if (cm_valid_i[c] && cm_wren_i[c] && (cm_rdindex_i[c*IW +: IW] == IW'(i)) &&
            ((ITAG_CHECK == 0) || (cm_itag_i[c*IDLEN +: IDLEN] == itag_q[i]))) begin
          cm_hit[i] = 1'b1;
        end
      end
      if ((ZERO_HARDWIRED != 0) && (i == 0)) begin
        upd_hit[i] = 1'b0;
        cm_hit[i]  = 1'b0;
        itag_d[i]  = itag_q[i];
      end

      if (flush_i) begin
        busy_d[i] = 1'b0;
        itag_d[i] = itag_q[i];
      end else if (upd_hit[i]) begin
        busy_d[i] = 1'b1;
      end else begin
        itag_d[i] = itag_q[i];
        if (cm_hit[i]) begin
          busy_d[i] = 1'b0;
        end
      end
    end

    cnt_d = '0;
    for (int i = 0; i < NREG; i++) begin
      cnt_d = cnt_d + CW'(busy_d[i]);
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      busy_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < NREG; i++) begin
        itag_q[i] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      for (int i = 0; i < NREG; i++) begin
        itag_q[i] <= itag_d[i];
      end
    end
  end

`ifdef PRV664_SCB_COMMIT_BYPASS_EN
  // A same-cycle update re-owns the register, and flush clears next cycle anyway.
  assign busy_o = busy_q & ~(cm_hit & ~upd_hit & {NREG{~flush_i}});
`else
  assign busy_o = busy_q;
`endif

  assign busy_cnt_o = cnt_q;

  for (genvar g = 0; g < NREG; g++) begin : g_itag
    assign itag_o[g*IDLEN +: IDLEN] = itag_q[g];
  end

endmodule

// File: tb/tb_prv664_mscoreboard.sv
// Scoreboard bench for prv664_mscoreboard: an integer-file instance (defaults) and an
// FP-file instance (register 0 tracked, unconditional commit) share stimulus against a behavioural model.
module tb_prv664_mscoreboard;

  logic         clk = 1'b0;
  logic         arst;
  logic         flush;
  logic [1:0]   uv, cv, cw;
  logic [4:0]   ur [2];
  logic [4:0]   cr [2];
  logic [7:0]   ut [2];
  logic [7:0]   ct [2];

  logic [31:0]  busy0, busy1;
  logic [255:0] itag0, itag1;
  logic [5:0]   cnt0, cnt1;

  always #5 clk = ~clk;

  prv664_mscoreboard dut_int (
    .clk_i(clk), .arst_i(arst), .flush_i(flush),
    .upd_valid_i(uv), .upd_rdindex_i({ur[1], ur[0]}), .upd_itag_i({ut[1], ut[0]}),
    .cm_valid_i(cv), .cm_wren_i(cw), .cm_rdindex_i({cr[1], cr[0]}), .cm_itag_i({ct[1], ct[0]}),
    .busy_o(busy0), .itag_o(itag0), .busy_cnt_o(cnt0)
  );

  prv664_mscoreboard #(.ITAG_CHECK(0), .ZERO_HARDWIRED(0)) dut_fp (
    .clk_i(clk), .arst_i(arst), .flush_i(flush),
    .upd_valid_i(uv), .upd_rdindex_i({ur[1], ur[0]}), .upd_itag_i({ut[1], ut[0]}),
    .cm_valid_i(cv), .cm_wren_i(cw), .cm_rdindex_i({cr[1], cr[0]}), .cm_itag_i({ct[1], ct[0]}),
    .busy_o(busy1), .itag_o(itag1), .busy_cnt_o(cnt1)
  );

  typedef struct {
    logic [31:0]  busy;
    logic [255:0] tag;
    logic [5:0]   cnt;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] m_busy [2];
  logic [7:0]  m_tag  [2][32];
  int          n_chk  = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = '0;
      for (int i = 0; i < 32; i++) m_tag[k][i] = '0;
    end
  endtask

  task automatic clear_inputs();
    flush = 1'b0; uv = '0; cv = '0; cw = '0;
    for (int p = 0; p < 2; p++) begin
      ur[p] = '0; ut[p] = '0; cr[p] = '0; ct[p] = '0;
    end
  endtask

  // One dispatch/commit cycle: drive, pre-edge busy check, push expectation, clock, pop and compare.
  task automatic step(input logic fl, input logic [1:0] v_u, input logic [4:0] u0, input logic [7:0] t0,
                      input logic [4:0] u1, input logic [7:0] t1, input logic [1:0] v_c,
                      input logic [4:0] c0, input logic [7:0] k0, input logic [4:0] c1, input logic [7:0] k1);
    logic [31:0] byp [2];
    logic [31:0] nb;
    exp_t        e;
    bit          uh, ch;
    logic [7:0]  nt;
    flush = fl; uv = v_u; cv = v_c; cw = v_c;
    ur[0] = u0; ut[0] = t0; ur[1] = u1; ut[1] = t1;
    cr[0] = c0; ct[0] = k0; cr[1] = c1; ct[1] = k1;
    #1;
    for (int k = 0; k < 2; k++) begin
      nb = m_busy[k];
      byp[k] = '0;
      for (int i = 0; i < 32; i++) begin
        uh = 0; ch = 0; nt = m_tag[k][i];
        for (int p = 0; p < 2; p++)
          if (uv[p] && ur[p] == 5'(i)) begin uh = 1; nt = ut[p]; end
        for (int c = 0; c < 2; c++)
          if (cv[c] && cw[c] && cr[c] == 5'(i) && (k == 1 || ct[c] == m_tag[k][i])) ch = 1;
        if (k == 0 && i == 0) begin uh = 0; ch = 0; end
        byp[k][i] = ch && !uh && !flush;
        if (flush) nb[i] = 1'b0;
        else if (uh) begin nb[i] = 1'b1; m_tag[k][i] = nt; end
        else if (ch) nb[i] = 1'b0;
      end
`ifndef PRV664_SCB_COMMIT_BYPASS_EN
      byp[k] = '0;
`endif
      check(k == 0 ? "int_busy_pre" : "fp_busy_pre", k == 0 ? busy0 : busy1, m_busy[k] & ~byp[k]);
      m_busy[k] = nb;
      e.busy = nb;
      for (int i = 0; i < 32; i++) e.tag[i*8 +: 8] = m_tag[k][i];
      e.cnt = 6'($countones(nb));
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    clear_inputs();
    #1;
    for (int k = 0; k < 2; k++) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        e = sb.pop_front();
        check(k == 0 ? "int_busy" : "fp_busy", k == 0 ? busy0 : busy1, e.busy);
        check(k == 0 ? "int_itag" : "fp_itag", k == 0 ? itag0 : itag1, e.tag);
        check(k == 0 ? "int_cnt"  : "fp_cnt",  k == 0 ? cnt0  : cnt1,  e.cnt);
      end
    end
  endtask

  function automatic logic [4:0] rnd_idx();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
  endfunction

  initial begin
    clear_inputs();
    model_reset();
    arst = 1'b1;
    #12;
    check("rst_int_busy", busy0, 0);
    check("rst_fp_busy",  busy1, 0);
    check("rst_int_itag", itag0, 0);
    check("rst_int_cnt",  cnt0, 0);
    check("rst_fp_cnt",   cnt1, 0);
    arst = 1'b0;
    @(posedge clk);
    #2;

    // basic set / clear
    step(0, 2'b01, 5, 8'h12, 0, 0, 2'b00, 0, 0, 0, 0);
    step(0, 2'b00, 0, 0, 0, 0, 2'b01, 5, 8'h12, 0, 0);
    // itag mismatch holds in the integer instance, then matching itag clears
    step(0, 2'b01, 7, 8'h20, 0, 0, 2'b00, 0, 0, 0, 0);
    step(0, 2'b00, 0, 0, 0, 0, 2'b01, 7, 8'h1F, 0, 0);
    step(0, 2'b00, 0, 0, 0, 0, 2'b10, 0, 0, 7, 8'h20);
    // younger port wins, update beats commit
    step(0, 2'b01, 3, 8'h01, 0, 0, 2'b00, 0, 0, 0, 0);
    step(0, 2'b11, 3, 8'h01, 3, 8'h02, 2'b01, 3, 8'h01, 0, 0);
    // flush overrides a same-cycle update
    step(0, 2'b11, 1, 8'hA1, 2, 8'hA2, 2'b00, 0, 0, 0, 0);
    step(0, 2'b01, 31, 8'hBF, 0, 0, 2'b00, 0, 0, 0, 0);
    step(1, 2'b01, 4, 8'h44, 0, 0, 2'b01, 3, 8'h02, 0, 0);
    // register 0: ignored in integer instance, tracked in FP instance
    step(0, 2'b01, 0, 8'h55, 0, 0, 2'b00, 0, 0, 0, 0);
    step(0, 2'b00, 0, 0, 0, 0, 2'b11, 0, 8'h55, 0, 8'h00);
    // dual commit to the same register, only one qualifying
    step(0, 2'b01, 6, 8'h66, 0, 0, 2'b00, 0, 0, 0, 0);
    step(0, 2'b00, 0, 0, 0, 0, 2'b11, 6, 8'h01, 6, 8'h66);

    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 24) == 0, 2'($urandom), rnd_idx(), 8'($urandom_range(0, 3)),
           rnd_idx(), 8'($urandom_range(0, 3)), 2'($urandom),
           rnd_idx(), 8'($urandom_range(0, 3)), rnd_idx(), 8'($urandom_range(0, 3)));
    end

    // same-cycle commit of r9 (bypass case), then async reset with r9 busy
    step(1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    step(0, 2'b01, 9, 8'h09, 0, 0, 2'b00, 0, 0, 0, 0);
    step(0, 2'b00, 0, 0, 0, 0, 2'b01, 9, 8'h09, 0, 0);
    step(0, 2'b10, 0, 0, 9, 8'h99, 2'b00, 0, 0, 0, 0);
    arst = 1'b1;
    #1;
    check("arst_int_busy", busy0, 0);
    check("arst_fp_busy",  busy1, 0);
    check("arst_int_itag", itag0, 0);
    check("arst_int_cnt",  cnt0, 0);
    #2;
    arst = 1'b0;
    model_reset();
    @(posedge clk);
    #2;
    step(0, 2'b01, 10, 8'h10, 0, 0, 2'b00, 0, 0, 0, 0);
    check("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/prv664_mscoreboard.md
Name: prv664_mscoreboard

Overview:
- Parametrised multi-port register scoreboard. Successor to the single-port integer/FP scoreboards; one instance per register file.
- Sits in the dispatch stage.
  - Dispatch marks destination registers busy with the owning instruction tag (itag).
  - Commit clears them, optionally gated by an itag match.
  - A flush clears every entry.
- Exposes per-register busy and owner-tag vectors plus a registered busy-entry count for stall heuristics.

Parameters:
- NREG, 32, number of architectural registers (≥2).
- IDLEN, 8, itag width.
- NWR, 2, dispatch update ports; higher index = younger in program order.
- NCM, 2, commit ports.
- ITAG_CHECK, 1, 1 = commit clears only on itag match (renaming mode); 0 = commit clears unconditionally.
- ZERO_HARDWIRED, 1, 1 = register 0 is never busy (integer file); 0 = register 0 is tracked (FP file).
- Local: IW = $clog2(NREG), CW = $clog2(NREG+1).

Ports:
- clk_i  in  1  clock, rising edge.
- arst_i  in  1  reset; asynchronous, active-high.
- flush_i  in  1  pipeline flush; clears all busy bits.
- upd_valid_i  in  NWR  dispatch update valid, one bit per port.
- upd_rdindex_i  in  NWR*IW  destination index per port; port k at bits [k*IW +: IW].
- upd_itag_i  in  NWR*IDLEN  owner itag per port.
- cm_valid_i  in  NCM  commit valid per port.
- cm_wren_i  in  NCM  commit writes a register in this file.
- cm_rdindex_i  in  NCM*IW  commit destination index per port.
- cm_itag_i  in  NCM*IDLEN  commit itag per port.
- busy_o  out  NREG  per-register busy flag.
- itag_o  out  NREG*IDLEN  per-register pending owner itag.
- busy_cnt_o  out  CW  number of busy registers, registered.

Behaviour:
- Reset (arst_i high, asynchronous): busy = 0, all itags = 0, busy_cnt_o = 0. Outputs are defined immediately; the reset takes effect mid-operation regardless of clock.
- Per register i, per clock, in priority order:
  1. flush_i = 1: busy[i] <= 0; itag unchanged. All same-cycle updates and commits are ignored.
  2. Any update port k hits (upd_valid_i[k] and index == i): busy[i] <= 1; itag[i] <= itag of the highest-index hitting port. An update wins over a same-cycle commit to the same register (the new owner survives).
  3. Any commit port c hits (cm_valid_i[c], cm_wren_i[c], index == i) and (ITAG_CHECK == 0 or cm_itag == itag[i]): busy[i] <= 0; itag[i] held. Multiple commits to the same register: clear if any qualifies.
  4. Otherwise hold.
- Index bounds: any index ≥ NREG, on update or commit, is ignored.
- ZERO_HARDWIRED = 1:
  - Updates and commits to index 0 are ignored.
  - busy_o[0] = 0 constant; itag_o[0] = 0.
- Commit on an already-idle register: no effect.
- Latency:
  - Update → busy_o set: 1 cycle (visible the cycle after the update).
  - Commit → busy_o cleared: 1 cycle (see optional feature).
- busy_cnt_o: next-state popcount of busy, registered. It equals the popcount of the registered busy vector every cycle, 1-cycle latency consistent with busy_o.
- No handshake back-pressure: the block always accepts updates and commits.

Optional Feature:
- Macro: PRV664_SCB_COMMIT_BYPASS_EN.
- Defined: busy_o[i] is additionally cleared combinationally in the same cycle by a qualifying commit (step 3 rule, including the itag check). It is not cleared if a same-cycle update targets i or flush_i is high; flush_i already clears next cycle, so the bypass does not apply during flush. This lets dispatch issue a dependent instruction one cycle earlier.
- Defined, unchanged: itag_o and busy_cnt_o stay registered.
- Not defined: busy_o is the registered busy vector only.

Test Plan:
- Reset then update port0 rd=5, itag=0x12 → next cycle busy_o[5]=1, itag_o[5]=0x12, busy_cnt_o=1; commit rd=5, itag=0x12 → next cycle busy_o[5]=0, count=0.
- ITAG_CHECK=1: busy rd=7 with itag 0x20, commit rd=7 itag 0x1F → busy_o[7] stays 1; commit with 0x20 → cleared.
- Same cycle: port0 rd=3 itag 0x01, port1 rd=3 itag 0x02, commit rd=3 itag 0x01 while 3 already busy with 0x01 → busy_o[3]=1, itag_o[3]=0x02.
- Busy r1, r2, r31 (count=3); flush_i with a simultaneous update of r4 → all busy_o=0, count=0, r4 not busy.
- ZERO_HARDWIRED=1: update rd=0 → busy_o[0]=0, count unchanged. ZERO_HARDWIRED=0: same stimulus → busy_o[0]=1.
- Assert arst_i asynchronously between edges with r9 busy → busy_o=0 before the next edge. With PRV664_SCB_COMMIT_BYPASS_EN: a qualifying commit of r9 → busy_o[9]=0 in the same cycle.
